// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame transmitter.
// SERIAL_FRAME_TX_PARITY_EN adds a PARITY state to the character FSM.
package serial_frame_pkg;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

    localparam logic LINE_IDLE = 1'b1;

    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_frame_tx_baud.sv
// Bit-period timer: counts while en is high, pulses tick once per clks_per_bit cycles.
module baud_tick_gen #(
    parameter int unsigned clks_per_bit = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int unsigned   CW   = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam logic [CW-1:0] LAST = CW'(clks_per_bit - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/serial_frame_tx.sv
// Serializes a words x width_byte frame as back-to-back UART characters on o_tx_0.
// Optional even parity bit per character under SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned width_byte   = 8,
    parameter int unsigned words        = 8,
    parameter int unsigned clks_per_bit = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [words*width_byte-1:0]   i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx_0,
    output logic                          o_busy,
    output logic                          o_done
);
    localparam int unsigned   BW        = $clog2(width_byte + 1);
    localparam int unsigned   YW        = (words > 1) ? $clog2(words + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(width_byte - 1);
    localparam logic [YW-1:0] LAST_BYTE = YW'(words - 1);

    tx_state_t                     state_q, state_d;
    logic [BW-1:0]                 bit_q, bit_d;
    logic [YW-1:0]                 byte_q, byte_d;
    logic [words*width_byte-1:0]   frame_q, frame_d;
    logic                          tx_q, tx_d;
    logic                          tick, accept, frame_end;
    logic [width_byte-1:0]         cur_byte, shifted;

    baud_tick_gen #(.clks_per_bit(clks_per_bit)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    // Ready/done are raised in the last stop-bit cycle so a new accept starts with no gap.
    assign frame_end = (state_q == STOP) && tick && (byte_q == LAST_BYTE);
    assign o_ready   = (state_q == IDLE) || frame_end;
    assign o_done    = frame_end;
    assign o_busy    = (state_q != IDLE);
    assign o_tx_0    = tx_q;
    assign accept    = i_valid && o_ready;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    bit_d   = '0;
                    byte_d  = '0;
                    frame_d = i_data;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (byte_q != LAST_BYTE) begin
                        state_d = START;
                        byte_d  = byte_q + 1'b1;
                    end else if (accept) begin
                        state_d = START;
                        bit_d   = '0;
                        byte_d  = '0;
                        frame_d = i_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is computed from the next state so o_tx_0 is a plain register.
    always_comb begin
        cur_byte = '0;
        for (int unsigned k = 0; k < words; k++) begin
            if (byte_d == YW'(k)) begin
                cur_byte = frame_q[k*width_byte +: width_byte];
            end
        end
        shifted = cur_byte >> bit_d;
        tx_d    = LINE_IDLE;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shifted[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PARITY: tx_d = even_parity(64'(cur_byte));
`endif
            default: tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '0;
            tx_q    <= LINE_IDLE;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx (width_byte=8, words=2, clks_per_bit=4).
module tb_serial_frame_tx;
    localparam int unsigned WB    = 8;
    localparam int unsigned WORDS = 2;
    localparam int unsigned CPB   = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int unsigned CH = WB + 3;
`else
    localparam int unsigned CH = WB + 2;
`endif
    localparam int unsigned NBITS = WORDS * CH;
    localparam int unsigned FL    = NBITS * CPB;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [WORDS*WB-1:0]   i_data;
    logic                  i_valid;
    logic                  o_ready, o_tx_0, o_busy, o_done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    serial_frame_tx #(.width_byte(WB), .words(WORDS), .clks_per_bit(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_tx_0  (o_tx_0),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: line level per bit time, bit time 0 at the MSB of the returned vector.
    function automatic logic [NBITS-1:0] model_line(input logic [WORDS*WB-1:0] d);
        logic q[$];
        logic [NBITS-1:0] r;
        logic [WB-1:0] b;
        for (int k = 0; k < WORDS; k++) begin
            b = d[k*WB +: WB];
            q.push_back(1'b0);
            for (int j = 0; j < WB; j++) q.push_back(b[j]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
            q.push_back(^b);
`endif
            q.push_back(1'b1);
        end
        for (int i = 0; i < NBITS; i++) r[NBITS-1-i] = q[i];
        return r;
    endfunction

    task automatic wait_ready(input string tag);
        int unsigned n = 0;
        while (o_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    endtask

    task automatic idle_check(input string tag, input int unsigned cycles);
        int unsigned bad = 0;
        for (int unsigned k = 0; k < cycles; k++) begin
            if (o_tx_0 !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_ready !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        chk({tag, "_idle"}, bad, 32'd0);
    endtask

    task automatic xmit(input logic [WORDS*WB-1:0] d, input logic [NBITS-1:0] exp,
                        input bit probe, input string tag);
        int unsigned mism = 0, done_cnt = 0, done_at = 0, busy_bad = 0, rdy_bad = 0;
        wait_ready(tag);
        i_data  = d;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_data  = (WORDS*WB)'($urandom);
        for (int i = 0; i < int'(FL); i++) begin
            if (o_tx_0 !== exp[NBITS-1-i/CPB]) mism++;
            if (o_done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
            if (o_busy !== 1'b1) busy_bad++;
            if (o_ready !== (i == int'(FL) - 1)) rdy_bad++;
            if (probe && i == 20) begin
                i_valid = 1'b1;
                i_data  = '1;
            end
            if (probe && i == 21) i_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk({tag, "_line"}, mism, 32'd0);
        chk({tag, "_done_cnt"}, done_cnt, 32'd1);
        chk({tag, "_done_at"}, done_at, FL - 1);
        chk({tag, "_busy"}, busy_bad, 32'd0);
        chk({tag, "_ready_seq"}, rdy_bad, 32'd0);
        idle_check(tag, 6);
    endtask

    typedef struct packed {
        logic [WORDS*WB-1:0] data;
        logic [NBITS-1:0]    exp;
        logic                probe;
        logic [3:0]          gap;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [NBITS-1:0] e1, e2;
        logic [WORDS*WB-1:0] rd;
        int unsigned mism, d1, d2, nd, t0;

`ifdef SERIAL_FRAME_TX_PARITY_EN
        vecs[0] = '{16'hA355, 22'b01010101001_01100010101, 1'b1, 4'd0};
        vecs[1] = '{16'h0000, 22'b00000000001_00000000001, 1'b0, 4'd3};
        vecs[2] = '{16'hFFFF, 22'b01111111101_01111111101, 1'b0, 4'd0};
        vecs[3] = '{16'h8001, 22'b01000000011_00000000111, 1'b0, 4'd5};
        vecs[4] = '{16'h0F0F, 22'b01111000001_01111000001, 1'b0, 4'd1};
`else
        vecs[0] = '{16'hA355, 20'b0101010101_0110001011, 1'b1, 4'd0};
        vecs[1] = '{16'h0000, 20'b0000000001_0000000001, 1'b0, 4'd3};
        vecs[2] = '{16'hFFFF, 20'b0111111111_0111111111, 1'b0, 4'd0};
        vecs[3] = '{16'h8001, 20'b0100000001_0000000011, 1'b0, 4'd5};
        vecs[4] = '{16'h0F0F, 20'b0111100001_0111100001, 1'b0, 4'd1};
`endif

        rst     = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_tx",    32'(o_tx_0),  32'd1);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_done",  32'(o_done),  32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            repeat (int'(vecs[v].gap)) @(posedge clk);
            #0;
            xmit(vecs[v].data, vecs[v].exp, vecs[v].probe, $sformatf("vec%0d", v));
        end

        // Back-to-back: valid held high across the o_done cycle.
        e1 = model_line(16'h0001);
        e2 = model_line(16'h8000);
        wait_ready("b2b");
        i_data  = 16'h0001;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_data = 16'h8000;
        mism = 0; d1 = 0; d2 = 0; nd = 0;
        for (int i = 0; i < int'(2*FL); i++) begin
            if (i < int'(FL)) begin
                if (o_tx_0 !== e1[NBITS-1-i/CPB]) mism++;
            end else begin
                if (o_tx_0 !== e2[NBITS-1-(i-int'(FL))/CPB]) mism++;
            end
            if (o_done === 1'b1) begin
                if (nd == 0) d1 = i; else d2 = i;
                nd++;
            end
            if (i == int'(FL)) i_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("b2b_line", mism, 32'd0);
        chk("b2b_done_cnt", nd, 32'd2);
        chk("b2b_done_gap", d2 - d1, FL);
        idle_check("b2b", 6);

        // Reset during byte 1 data bit 1 (0x55 bit 1 is 0, so the line is low beforehand).
        wait_ready("mrst");
        i_data  = 16'h5500;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        t0 = CH*CPB + 2*CPB + 1;
        repeat (t0) @(posedge clk);
        #1;
        chk("mrst_pre_tx", 32'(o_tx_0), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("mrst_async_tx",    32'(o_tx_0),  32'd1);
        chk("mrst_async_busy",  32'(o_busy),  32'd0);
        chk("mrst_async_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_check("mrst_after", 3*FL);

        for (int r = 0; r < 6; r++) begin
            rd = (WORDS*WB)'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #0;
            xmit(rd, model_line(rd), 1'b0, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
